// File: rtl/vram_pkg.sv
// Shared constants and state encoding for the frame-buffer reader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vram_pkg;

    localparam int WORD_W    = 32;
    localparam int BIT_CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/vram_fifo.sv
// Small synchronous word FIFO with occupancy count and synchronous flush.
// Latency: a word pushed at edge N is visible on rd_dat after edge N.
// Backpressure: none internal; writer must respect count (push when full and pop when empty are dropped).
//
// Ports:
//   clk, reset      clock, async active-high reset
//   flush           clears the FIFO at the next edge, wins over push/pop
//   wr_vld, wr_dat  push a word
//   rd_rdy          pop the head word
//   rd_dat          head word (valid when count != 0)
//   count           number of stored words, 0..DEPTH
module vram_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       wr_vld,
    input  logic [W-1:0]               wr_dat,
    input  logic                       rd_rdy,
    output logic [W-1:0]               rd_dat,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_wr;
    logic          do_rd;

    assign do_wr  = wr_vld && (count != (AW+1)'(DEPTH));
    assign do_rd  = rd_rdy && (count != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (do_wr && !flush) mem[wr_ptr] <= wr_dat;
    end

endmodule

// File: rtl/vram_reader.sv
// Frame-buffer reader: fetches WORDS RAM words after frame_start and serializes them MSB-first.
// Latency: frame_start at E0 -> mem_rd in E0..E1 -> FIFO at E2 -> pix_valid from E3.
// Backpressure: pix_req stalls the shifter; reads stop when FIFO plus in-flight reaches DEPTH.
//
// Ports:
//   clk, reset             clock, async active-high reset
//   frame_start            restart pulse
//   mem_rd, mem_addr       RAM read request (combinational from registered state)
//   mem_rdata              RAM data, valid the cycle after mem_rd
//   pix_req                consumer takes the current pixel this cycle
//   pix_valid, pix         current pixel
//   underrun               sticky: pixel requested while none available during a frame
//   done                   whole frame fetched and consumed
module vram_reader
    import vram_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int BASE   = 0,
    parameter int WORDS  = 328,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    input  logic              pix_req,
    output logic              pix_valid,
    output logic              pix,
    output logic              underrun,
    output logic              done
);

    localparam int CNT_W = $clog2(DEPTH) + 1;
    // One extra bit so issued can reach WORDS == 2^ADDR_W.
    localparam int ISS_W = ADDR_W + 1;

    state_t                 state;
    logic [ISS_W-1:0]       issued;
    logic                   inflight;
    logic [WORD_W-1:0]      shreg;
    logic [BIT_CNT_W-1:0]   bit_cnt;

    logic [CNT_W-1:0]       fifo_count;
    logic [WORD_W-1:0]      fifo_head;

    logic                   consume;
    logic                   last_bit;
    logic                   sh_free;
    logic                   load;
    logic                   all_issued;
    logic                   credit_ok;
    logic                   frame_end;

    // Credit covers the word still on the RAM return path, so the FIFO cannot overflow.
    assign all_issued = (issued == ISS_W'(WORDS));
    assign credit_ok  = ((CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight)) < (CNT_W+1)'(DEPTH);
    assign mem_rd     = (state == FETCH) && !all_issued && credit_ok;
    assign mem_addr   = ADDR_W'(BASE) + issued[ADDR_W-1:0];

    assign consume  = pix_req && pix_valid;
    assign last_bit = consume && (bit_cnt == BIT_CNT_W'(WORD_W-1));
    // Shifter is free now or becomes free at this edge; refilling in the same
    // edge as the last bit avoids a bubble between words.
    assign sh_free  = !pix_valid || last_bit;
    assign load     = (state == FETCH) && sh_free && (fifo_count != '0);

    assign frame_end = all_issued && !inflight && (fifo_count == '0) && sh_free;

    assign pix = shreg[WORD_W-1];

    vram_fifo #(
        .W     (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .flush  (frame_start),
        .wr_vld (inflight),
        .wr_dat (mem_rdata),
        .rd_rdy (load),
        .rd_dat (fifo_head),
        .count  (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            issued    <= '0;
            inflight  <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
            done      <= 1'b0;
        end else if (frame_start) begin
            // Restart wins over any pixel consume or returning read this edge.
            state     <= FETCH;
            issued    <= '0;
            inflight  <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            pix_valid <= 1'b0;
            underrun  <= 1'b0;
            done      <= 1'b0;
        end else begin
            inflight <= mem_rd;
            if (mem_rd) issued <= issued + ISS_W'(1);

            if ((state == FETCH) && pix_req && !pix_valid) underrun <= 1'b1;

            if (load) begin
                shreg     <= fifo_head;
                bit_cnt   <= '0;
                pix_valid <= 1'b1;
            end else if (consume) begin
                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                if (last_bit) pix_valid <= 1'b0;
            end

            case (state)
                FETCH: begin
                    if (frame_end) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_reader.sv
// Self-checking bench for vram_reader: RAM model, per-cycle reference checks, directed scenarios.
// Latency: n/a.
// Backpressure: pix_req driven directed or random.
module tb_vram_reader;

    localparam int ADDR_W = 9;
    localparam int BASE   = 3;
    localparam int WORDS  = 12;
    localparam int DEPTH  = 4;
    localparam int NBITS  = WORDS * 32;

    logic              clk         = 1'b0;
    logic              reset       = 1'b0;
    logic              frame_start = 1'b0;
    logic              pix_req     = 1'b0;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata   = 32'h0;
    logic              pix_valid;
    logic              pix;
    logic              underrun;
    logic              done;

    logic [31:0] ram [0:(1<<ADDR_W)-1];

    int tests = 0;
    int fails = 0;

    // Reference model state, updated once per cycle at the falling edge.
    int m_reads   = 0;
    int m_cons    = 0;
    bit m_started = 1'b0;
    bit m_under   = 1'b0;

    vram_reader #(
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .WORDS  (WORDS),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .frame_start (frame_start),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .pix_req     (pix_req),
        .pix_valid   (pix_valid),
        .pix         (pix),
        .underrun    (underrun),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Synchronous RAM; garbage on idle cycles exposes unrequested captures.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= ram[mem_addr];
        else        mem_rdata <= $urandom();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input int i);
        logic [31:0] w;
        w = ram[BASE + i / 32];
        return w[31 - (i % 32)];
    endfunction

    always @(negedge clk) begin
        bit fin;
        if (reset) begin
            m_reads   = 0;
            m_cons    = 0;
            m_started = 1'b0;
            m_under   = 1'b0;
            check("rst_mem_rd",   32'(mem_rd),    0);
            check("rst_mem_addr", 32'(mem_addr),  BASE);
            check("rst_pix_vld",  32'(pix_valid), 0);
            check("rst_pix",      32'(pix),       0);
            check("rst_underrun", 32'(underrun),  0);
            check("rst_done",     32'(done),      0);
        end else begin
            fin = m_started && (m_cons == NBITS);
            check("done",     32'(done),     32'(fin));
            check("underrun", 32'(underrun), 32'(m_under));
            if (!m_started || fin) begin
                check("quiet_rd",  32'(mem_rd),    0);
                check("quiet_vld", 32'(pix_valid), 0);
            end
            if (mem_rd) begin
                check("rd_addr",  32'(mem_addr), 32'(BASE + m_reads));
                check("rd_limit", 32'(m_reads < WORDS), 1);
            end
            if (pix_valid) begin
                check("pix_range", 32'(m_cons < NBITS), 1);
                if (m_cons < NBITS) check("pix", 32'(pix), 32'(exp_bit(m_cons)));
            end
            // FIFO + in-flight bounded by DEPTH, plus one word in the shifter.
            check("credit", 32'((m_reads - m_cons / 32) <= DEPTH + 1), 1);

            if (frame_start) begin
                m_started = 1'b1;
                m_reads   = 0;
                m_cons    = 0;
                m_under   = 1'b0;
            end else begin
                if (mem_rd) m_reads++;
                if (m_started && !fin && pix_req && !pix_valid) m_under = 1'b1;
                if (pix_req && pix_valid) m_cons++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at E0+1.
    task automatic pulse_start(input bit req);
        frame_start = 1'b1;
        pix_req     = req;
        step();
        frame_start = 1'b0;
    endtask

    task automatic run_frame(input int density, input int restart_at);
        int cyc;
        bit restarted;
        for (int i = 0; i < WORDS; i++) ram[BASE + i] = $urandom();
        pulse_start(1'b0);
        cyc       = 0;
        restarted = (restart_at < 0);
        while (!done && cyc < 6000) begin
            pix_req = ($urandom_range(0, 99) < density);
            if (!restarted && cyc >= restart_at && mem_rd) begin
                frame_start = 1'b1;
                restarted   = 1'b1;
            end
            step();
            frame_start = 1'b0;
            cyc++;
        end
        check("frame_done", 32'(done), 1);
        pix_req = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] got;
        int bubbles;
        int n;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = $urandom();
        ram[BASE] = 32'h8000_0001;

        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check("idle_rd",    32'(mem_rd),    0);
        check("idle_addr",  32'(mem_addr),  BASE);
        check("idle_valid", 32'(pix_valid), 0);
        check("idle_done",  32'(done),      0);
        step();

        // First-word latency and MSB-first order, pix_req high from the start.
        pulse_start(1'b1);
        check("e0_mem_rd", 32'(mem_rd),   1);
        check("e0_addr",   32'(mem_addr), BASE);
        step();
        check("e1_valid",    32'(pix_valid), 0);
        check("e1_underrun", 32'(underrun),  1);
        check("e1_addr",     32'(mem_addr),  BASE + 1);
        step();
        check("e2_valid", 32'(pix_valid), 0);
        step();
        check("e3_valid", 32'(pix_valid), 1);
        got = '0;
        for (int i = 0; i < 32; i++) begin
            got[31 - i] = pix;
            step();
        end
        check("first_word", got, 32'h8000_0001);
        check("underrun_sticky", 32'(underrun), 1);

        // Consumer stalled: FIFO fills to the credit limit, then one word frees one slot.
        pulse_start(1'b0);
        check("restart_clears_underrun", 32'(underrun), 0);
        repeat (20) step();
        check("fill_reads",  32'(m_reads), DEPTH + 1);
        check("fill_rd_off", 32'(mem_rd),  0);
        check("fill_valid",  32'(pix_valid), 1);
        pix_req = 1'b1;
        repeat (32) step();
        pix_req = 1'b0;
        repeat (10) step();
        check("refill_reads", 32'(m_reads), DEPTH + 2);
        check("no_underrun",  32'(underrun), 0);

        // Continuous consume from a full buffer: no gaps up to the end of frame.
        pix_req = 1'b1;
        bubbles = 0;
        n       = 0;
        while (!done && n < 3000) begin
            if (!pix_valid) bubbles++;
            step();
            n++;
        end
        check("no_bubble",  32'(bubbles), 0);
        check("end_done",   32'(done),    1);
        check("end_consumed", 32'(m_cons), NBITS);
        repeat (3) step();
        check("done_ignores_req", 32'(underrun), 0);
        check("done_hold",        32'(done),     1);
        check("done_rd_off",      32'(mem_rd),   0);
        pix_req = 1'b0;

        // Random backpressure, with restarts while reads are outstanding.
        run_frame(30, -1);
        run_frame(70, 50);
        run_frame(100, 5);
        run_frame(50, 200);
        run_frame(90, 2);

        // Async reset mid-frame, between clock edges.
        pulse_start(1'b1);
        repeat (10) step();
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_mem_rd",   32'(mem_rd),    0);
        check("arst_addr",     32'(mem_addr),  BASE);
        check("arst_valid",    32'(pix_valid), 0);
        check("arst_pix",      32'(pix),       0);
        check("arst_underrun", 32'(underrun),  0);
        check("arst_done",     32'(done),      0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        pix_req = 1'b1;
        repeat (5) step();
        check("post_rst_rd",       32'(mem_rd),    0);
        check("post_rst_valid",    32'(pix_valid), 0);
        check("post_rst_underrun", 32'(underrun),  0);
        pix_req = 1'b0;
        run_frame(60, -1);

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
